// File: rtl/command_definition_pkg.sv
// Shared command types, scheduler state encoding and default DRAM timing
// constants for the bank timing scheduler.
package command_definition_pkg;

  localparam int ADDR_BITS     = 14;
  localparam int DEF_NUM_BANKS = 8;
  localparam int PKG_BA_W      = $clog2(DEF_NUM_BANKS);
  localparam int DEF_COL_BITS  = 10;
  localparam int DEF_T_RCD     = 11;
  localparam int DEF_T_RP      = 11;
  localparam int DEF_T_RAS     = 28;
  localparam int DEF_T_CCD     = 4;
  localparam int DEF_T_WTR     = 6;
  localparam int DEF_CNT_W     = 6;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } command_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef struct packed {
    op_t                     op;
    logic [PKG_BA_W-1:0]     bank_addr;
    logic [ADDR_BITS-1:0]    row_addr;
    logic [DEF_COL_BITS-1:0] col_addr;
  } bank_command_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_WAIT_PRE = 3'd3,
    ST_WAIT_ACT = 3'd4,
    ST_WAIT_CAS = 3'd5
  } sched_state_t;

endpackage

// File: rtl/bank_state_tracker.sv
// Per-bank open-row state plus the bank's general (tRCD/tRP) and tRAS
// countdown timers; loaded by ACT/PRE strobes from the scheduler FSM.
module bank_state_tracker
  import command_definition_pkg::*;
#(
  parameter int ROW_BITS = ADDR_BITS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_RAS    = DEF_T_RAS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_act,
  input  logic                i_pre,
  input  logic [ROW_BITS-1:0] i_row,
  output logic                o_open,
  output logic [ROW_BITS-1:0] o_row,
  output logic                o_gen_zero,
  output logic                o_ras_zero
);

  logic                r_open;
  logic [ROW_BITS-1:0] r_row;
  logic [CNT_W-1:0]    r_gen;
  logic [CNT_W-1:0]    r_ras;

  // Open-row bookkeeping and saturating timers; ACT/PRE reload, otherwise count down.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_open <= 1'b0;
      r_row  <= '0;
      r_gen  <= '0;
      r_ras  <= '0;
    end else if (i_act) begin
      r_open <= 1'b1;
      r_row  <= i_row;
      r_gen  <= CNT_W'(T_RCD - 1);
      r_ras  <= CNT_W'(T_RAS - 1);
    end else begin
      r_open <= i_pre ? 1'b0 : r_open;
      r_row  <= r_row;
      if (i_pre) begin
        r_gen <= CNT_W'(T_RP - 1);
      end else begin
        r_gen <= (r_gen != '0) ? r_gen - CNT_W'(1) : r_gen;
      end
      r_ras <= (r_ras != '0) ? r_ras - CNT_W'(1) : r_ras;
    end
  end

  assign o_open     = r_open;
  assign o_row      = r_row;
  assign o_gen_zero = (r_gen == '0);
  assign o_ras_zero = (r_ras == '0);

endmodule

// File: rtl/bank_timing_scheduler.sv
// Pops one request at a time, expands it into PRE/ACT/RD/WR while honouring
// per-bank tRCD/tRP/tRAS and global tCCD/tWTR, one command per cycle to the PHY.
module bank_timing_scheduler
  import command_definition_pkg::*;
#(
  parameter int  NUM_BANKS = DEF_NUM_BANKS,
  parameter int  ROW_BITS  = ADDR_BITS,
  parameter int  COL_BITS  = DEF_COL_BITS,
  parameter int  T_RCD     = DEF_T_RCD,
  parameter int  T_RP      = DEF_T_RP,
  parameter int  T_RAS     = DEF_T_RAS,
  parameter int  T_CCD     = DEF_T_CCD,
  parameter int  T_WTR     = DEF_T_WTR,
  parameter int  CNT_W     = DEF_CNT_W,
  localparam int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                init_done_flag,
  input  logic                issue_queue_empty,
  output logic                issue_queue_ren,
  input  bank_command_t       issue_queue_cmd,
  input  logic                write_data_fifo_empty,
  output command_t            o_command,
  output logic [BA_W-1:0]     o_bank_addr,
  output logic [ROW_BITS-1:0] o_row_addr,
  output logic [COL_BITS-1:0] o_col_addr,
  output logic                o_busy
);

  sched_state_t        r_state;
  sched_state_t        w_next_state;
  bank_command_t       r_req;
  logic [CNT_W-1:0]    r_ccd;
  logic [CNT_W-1:0]    r_wtr;

  logic [NUM_BANKS-1:0] w_open;
  logic [NUM_BANKS-1:0] w_gen_zero;
  logic [NUM_BANKS-1:0] w_ras_zero;
  logic [NUM_BANKS-1:0] w_act_sel;
  logic [NUM_BANKS-1:0] w_pre_sel;
  logic [ROW_BITS-1:0]  w_row [NUM_BANKS];

  logic     w_row_hit;
  logic     w_can_pre;
  logic     w_can_act;
  logic     w_can_cas;
  command_t w_cmd;
  logic     w_ren;
  logic     w_latch;
  logic     w_act;
  logic     w_pre;
  logic     w_cas;
  logic     w_busy;

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      assign w_act_sel[g] = w_act && (r_req.bank_addr == BA_W'(g));
      assign w_pre_sel[g] = w_pre && (r_req.bank_addr == BA_W'(g));
      bank_state_tracker #(
        .ROW_BITS(ROW_BITS), .CNT_W(CNT_W),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)
      ) u_tracker (
        .i_clk      (clk1),
        .i_rst_n    (rst_n),
        .i_clear    (!init_done_flag),
        .i_act      (w_act_sel[g]),
        .i_pre      (w_pre_sel[g]),
        .i_row      (r_req.row_addr),
        .o_open     (w_open[g]),
        .o_row      (w_row[g]),
        .o_gen_zero (w_gen_zero[g]),
        .o_ras_zero (w_ras_zero[g])
      );
    end
  endgenerate

  assign w_row_hit = w_open[r_req.bank_addr] && (w_row[r_req.bank_addr] == r_req.row_addr);
  assign w_can_pre = w_ras_zero[r_req.bank_addr] && w_gen_zero[r_req.bank_addr];
  assign w_can_act = w_gen_zero[r_req.bank_addr];
  // Reads wait out tWTR; writes wait for their data burst to be staged.
  assign w_can_cas = w_gen_zero[r_req.bank_addr] && (r_ccd == '0) &&
                     ((r_req.op == OP_READ) ? (r_wtr == '0) : !write_data_fifo_empty);

  // FSM state register.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; losing init forces IDLE from anywhere.
  always_comb begin
    w_next_state = r_state;
    if (!init_done_flag) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_next_state = ST_FETCH;
        ST_FETCH:    w_next_state = issue_queue_empty ? ST_FETCH : ST_DECODE;
        ST_DECODE: begin
          if (!w_open[r_req.bank_addr]) begin
            w_next_state = ST_WAIT_ACT;
          end else begin
            w_next_state = w_row_hit ? ST_WAIT_CAS : ST_WAIT_PRE;
          end
        end
        ST_WAIT_PRE: w_next_state = w_can_pre ? ST_WAIT_ACT : ST_WAIT_PRE;
        ST_WAIT_ACT: w_next_state = w_can_act ? ST_WAIT_CAS : ST_WAIT_ACT;
        ST_WAIT_CAS: w_next_state = w_can_cas ? ST_FETCH : ST_WAIT_CAS;
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM output decode: command choice and strobes for the next edge.
  always_comb begin
    w_cmd   = CMD_NOP;
    w_ren   = 1'b0;
    w_latch = 1'b0;
    w_act   = 1'b0;
    w_pre   = 1'b0;
    w_cas   = 1'b0;
    if (init_done_flag) begin
      case (r_state)
        ST_FETCH: begin
          w_ren   = !issue_queue_empty;
          w_latch = !issue_queue_empty;
        end
        ST_WAIT_PRE: begin
          w_pre = w_can_pre;
          w_cmd = w_can_pre ? CMD_PRE : CMD_NOP;
        end
        ST_WAIT_ACT: begin
          w_act = w_can_act;
          w_cmd = w_can_act ? CMD_ACT : CMD_NOP;
        end
        ST_WAIT_CAS: begin
          w_cas = w_can_cas;
          if (w_can_cas) begin
            w_cmd = (r_req.op == OP_WRITE) ? CMD_WR : CMD_RD;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        default: w_cmd = CMD_NOP;
      endcase
    end else begin
      w_cmd = CMD_NOP;
    end
  end

  assign w_busy = (w_next_state == ST_DECODE)   || (w_next_state == ST_WAIT_PRE) ||
                  (w_next_state == ST_WAIT_ACT) || (w_next_state == ST_WAIT_CAS);

  // Held request; dropped when init goes away.
  always_ff @(posedge clk1) begin
    if (!rst_n || !init_done_flag) begin
      r_req <= '0;
    end else if (w_latch) begin
      r_req <= issue_queue_cmd;
    end else begin
      r_req <= r_req;
    end
  end

  // Global CAS-to-CAS and write-to-read timers.
  always_ff @(posedge clk1) begin
    if (!rst_n || !init_done_flag) begin
      r_ccd <= '0;
      r_wtr <= '0;
    end else begin
      if (w_cas) begin
        r_ccd <= CNT_W'(T_CCD - 1);
      end else begin
        r_ccd <= (r_ccd != '0) ? r_ccd - CNT_W'(1) : r_ccd;
      end
      if (w_cas && (r_req.op == OP_WRITE)) begin
        r_wtr <= CNT_W'(T_WTR - 1);
      end else begin
        r_wtr <= (r_wtr != '0) ? r_wtr - CNT_W'(1) : r_wtr;
      end
    end
  end

  // Registered PHY/queue outputs; addresses read zero on NOP.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      o_command       <= CMD_NOP;
      o_bank_addr     <= '0;
      o_row_addr      <= '0;
      o_col_addr      <= '0;
      issue_queue_ren <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_command       <= w_cmd;
      o_bank_addr     <= (w_cmd != CMD_NOP) ? r_req.bank_addr : '0;
      o_row_addr      <= (w_cmd == CMD_ACT) ? r_req.row_addr : '0;
      o_col_addr      <= w_cas ? r_req.col_addr : '0;
      issue_queue_ren <= w_ren;
      o_busy          <= w_busy;
    end
  end

endmodule

// File: tb/tb_bank_timing_scheduler.sv
// Scoreboard bench: expected PHY commands with their cycle offsets are queued
// as requests are staged and checked as the scheduler emits them.
module tb_bank_timing_scheduler;
  import command_definition_pkg::*;

  typedef struct {
    command_t cmd;
    int       bank;
    int       addr;
    int       rk;   // 0: from last pop, 1: from previous command, 2: from write release
    int       dl;
    string    tag;
  } exp_t;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done_flag = 1'b0;
  logic          issue_queue_empty = 1'b1;
  logic          issue_queue_ren;
  bank_command_t issue_queue_cmd = '0;
  logic          write_data_fifo_empty = 1'b1;
  command_t      o_command;
  logic [2:0]    o_bank_addr;
  logic [13:0]   o_row_addr;
  logic [9:0]    o_col_addr;
  logic          o_busy;

  bank_command_t iq[$];
  exp_t          sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int last_cmd_cyc = 0;
  int rel_cyc = 0;

  bank_timing_scheduler dut (
    .clk1                  (clk1),
    .rst_n                 (rst_n),
    .init_done_flag        (init_done_flag),
    .issue_queue_empty     (issue_queue_empty),
    .issue_queue_ren       (issue_queue_ren),
    .issue_queue_cmd       (issue_queue_cmd),
    .write_data_fifo_empty (write_data_fifo_empty),
    .o_command             (o_command),
    .o_bank_addr           (o_bank_addr),
    .o_row_addr            (o_row_addr),
    .o_col_addr            (o_col_addr),
    .o_busy                (o_busy)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic req_add(input op_t op, input int b, input int r, input int c);
    bank_command_t x;
    x.op        = op;
    x.bank_addr = 3'(b);
    x.row_addr  = 14'(r);
    x.col_addr  = 10'(c);
    iq.push_back(x);
  endtask

  task automatic exp_add(input command_t c, input int b, input int a,
                         input int rk, input int dl, input string tg);
    exp_t e;
    e.cmd = c; e.bank = b; e.addr = a; e.rk = rk; e.dl = dl; e.tag = tg;
    sb.push_back(e);
  endtask

  // Queue model and output monitor, sampled away from the active edge.
  always @(negedge clk1) begin
    exp_t e;
    int   refc;
    if (issue_queue_ren) begin
      check_eq("ren_nonempty", int'(issue_queue_empty), 0);
      pop_cyc = cyc;
      if (iq.size() > 0) void'(iq.pop_front());
    end
    if (o_command != CMD_NOP) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_cmd", int'(o_command), int'(CMD_NOP));
      end else begin
        e = sb.pop_front();
        check_eq({e.tag, "_cmd"}, int'(o_command), int'(e.cmd));
        check_eq({e.tag, "_bank"}, int'(o_bank_addr), e.bank);
        if (e.cmd == CMD_ACT) check_eq({e.tag, "_row"}, int'(o_row_addr), e.addr);
        if (e.cmd == CMD_RD || e.cmd == CMD_WR) check_eq({e.tag, "_col"}, int'(o_col_addr), e.addr);
        refc = (e.rk == 0) ? pop_cyc : ((e.rk == 1) ? last_cmd_cyc : rel_cyc);
        check_eq({e.tag, "_cyc"}, cyc - refc, e.dl);
      end
      last_cmd_cyc = cyc;
    end
    issue_queue_empty = (iq.size() == 0);
    issue_queue_cmd   = (iq.size() > 0) ? iq[0] : '0;
  end

  task automatic wait_pop(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (!issue_queue_ren && n < bound);
    check_eq("pop_seen", int'(issue_queue_ren), 1);
  endtask

  task automatic drain(input int bound, input int idle);
    int n = 0;
    while ((sb.size() != 0 || iq.size() != 0 || o_busy) && n < bound) begin
      @(negedge clk1);
      n++;
    end
    check_eq("drain_sb", sb.size(), 0);
    repeat (idle) @(negedge clk1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values, then idle with a waiting request while init is low.
    req_add(OP_READ, 2, 'h15, 'h40);
    repeat (3) @(negedge clk1);
    check_eq("rst_cmd", int'(o_command), int'(CMD_NOP));
    check_eq("rst_ren", int'(issue_queue_ren), 0);
    check_eq("rst_busy", int'(o_busy), 0);
    check_eq("rst_bank", int'(o_bank_addr), 0);
    check_eq("rst_row", int'(o_row_addr), 0);
    check_eq("rst_col", int'(o_col_addr), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      check_eq("noinit_ren", int'(issue_queue_ren), 0);
      check_eq("noinit_cmd", int'(o_command), int'(CMD_NOP));
    end

    // Closed bank: ACT two cycles after pop, RD tRCD later.
    exp_add(CMD_ACT, 2, 'h15, 0, 2, "a_act");
    exp_add(CMD_RD, 2, 'h40, 1, 11, "a_rd");
    init_done_flag = 1'b1;
    wait_pop(10, n);
    check_eq("pop_after_init", n, 2);
    drain(200, 40);

    // Two row hits: first RD at pop+2, second tCCD after it.
    req_add(OP_READ, 2, 'h15, 'h40);
    req_add(OP_READ, 2, 'h15, 'h48);
    exp_add(CMD_RD, 2, 'h40, 0, 2, "b_rd0");
    exp_add(CMD_RD, 2, 'h48, 1, 4, "b_rd1");
    drain(200, 40);

    // Row conflict right behind an ACT: PRE at ACT+tRAS, then ACT, then RD.
    req_add(OP_READ, 5, 'h15, 'h10);
    req_add(OP_READ, 5, 'h20, 'h18);
    exp_add(CMD_ACT, 5, 'h15, 0, 2, "c_act0");
    exp_add(CMD_RD, 5, 'h10, 1, 11, "c_rd0");
    exp_add(CMD_PRE, 5, 0, 1, 17, "c_pre");
    exp_add(CMD_ACT, 5, 'h20, 1, 11, "c_act1");
    exp_add(CMD_RD, 5, 'h18, 1, 11, "c_rd1");
    drain(300, 40);

    // Write stalled on empty data FIFO, then a read held off by tWTR.
    req_add(OP_WRITE, 5, 'h20, 'h30);
    wait_pop(20, n);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) req_add(OP_READ, 5, 'h20, 'h38);
      @(negedge clk1);
      check_eq("d_stall_busy", int'(o_busy), 1);
    end
    exp_add(CMD_WR, 5, 'h30, 2, 1, "d_wr");
    exp_add(CMD_RD, 5, 'h38, 1, 6, "d_rd");
    rel_cyc = cyc;
    write_data_fifo_empty = 1'b0;
    drain(200, 40);

    // Reset pulse while waiting to activate; next access needs a fresh ACT.
    req_add(OP_READ, 3, 'h7, 'h5);
    wait_pop(20, n);
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    check_eq("e_rst_cmd", int'(o_command), int'(CMD_NOP));
    check_eq("e_rst_ren", int'(issue_queue_ren), 0);
    check_eq("e_rst_busy", int'(o_busy), 0);
    check_eq("e_rst_bank", int'(o_bank_addr), 0);
    check_eq("e_rst_row", int'(o_row_addr), 0);
    check_eq("e_rst_col", int'(o_col_addr), 0);
    rst_n = 1'b1;
    req_add(OP_READ, 2, 'h15, 'h60);
    exp_add(CMD_ACT, 2, 'h15, 0, 2, "e_act");
    exp_add(CMD_RD, 2, 'h60, 1, 11, "e_rd");
    drain(200, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
